// File: rtl/parity_stream_checker.sv
// rtl/parity_stream_checker.sv - streaming parity checker with saturating error count and latched link fault
module parity_stream_checker #(
    parameter int DATA_W  = 6,
    parameter int CNT_W   = 8,
    parameter int FAULT_N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              odd_mode,
    input  logic              clear,
    output logic              out_valid,
    output logic [DATA_W-2:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              fault
);

    localparam int STREAK_W = $clog2(FAULT_N + 1);
    localparam logic [STREAK_W-1:0] FAULT_LIM = STREAK_W'(FAULT_N);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_OK    = 2'd0;
    localparam logic [1:0] S_ERR   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]          state;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_inc;
    logic                accept;
    logic                err;

    assign in_ready   = (state != S_FAULT);
    assign fault      = (state == S_FAULT);
    assign accept     = in_valid & in_ready;
    // Even mode flags an odd population count; odd mode flags an even one.
    assign err        = (^in_data) ^ odd_mode;
    assign streak_inc = streak + STREAK_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_data <= in_data[DATA_W-2:0];
                out_err  <= err;
            end
        end
    end

    // A word accepted during clear is still emitted above but leaves the health state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OK;
            streak    <= '0;
            err_count <= '0;
        end else if (clear) begin
            state     <= S_OK;
            streak    <= '0;
            err_count <= '0;
        end else if (accept && err) begin
            if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
            case (state)
                S_OK: begin
                    streak <= STREAK_ONE;
                    state  <= (FAULT_N == 1) ? S_FAULT : S_ERR;
                end
                S_ERR: begin
                    streak <= streak_inc;
                    if (streak_inc == FAULT_LIM) begin
                        state <= S_FAULT;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end else if (accept) begin
            streak <= '0;
            state  <= S_OK;
        end
    end

endmodule
